startup_seq: RTL and testbench



---
 rtl/eq_pkg.sv | 32 +++
 rtl/startup_seq_lr_gap_mon.sv | 48 ++++
 rtl/startup_seq.sv | 166 ++++++++++++++++
 tb/tb_startup_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared types and timing defaults for the audio-path startup sequencer
// and its I2S presence monitor.
package eq_pkg;

    typedef enum logic [2:0] {
        ST_PWR   = 3'd0,
        ST_CFG   = 3'd1,
        ST_CFGW  = 3'd2,
        ST_LOCK  = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_t;

    localparam int DEF_PWR_DLY    = 32'sd50000;
    localparam int DEF_CFG_TMO    = 32'sd40000;
    localparam int DEF_MAX_RETRY  = 32'sd3;
    localparam int DEF_LOCK_EDGES = 32'sd8;
    localparam int DEF_MAX_GAP    = 32'sd4096;
    localparam int DEF_AMP_DLY    = 32'sd1024;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/startup_seq_lr_gap_mon.sv
// LRCLK presence monitor: rising-edge pulse plus a saturating count of
// clk cycles since the last rising edge.
module lr_gap_mon
    import eq_pkg::*;
#(
    parameter int MAX_GAP = DEF_MAX_GAP
) (
    input  logic clk,
    input  logic rst,
    input  logic lrclk,
    output logic lr_rise,
    output logic gap_exceeded
);

    // The count must be able to hold MAX_GAP itself, since it saturates there.
    localparam int               GAP_W   = cnt_w(MAX_GAP + 32'sd1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MAX_GAP);

    logic             lrclk_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;

    // Edge detect and next gap count; the limit flag is taken from the next
    // value so consumers react on the same edge the count reaches MAX_GAP.
    always_comb begin
        lr_rise = lrclk & ~lrclk_q;
        if (lr_rise) begin
            gap_d = {GAP_W{1'b0}};
        end else if (gap_q == GAP_MAX) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + GAP_W'(1);
        end
        gap_exceeded = (gap_d == GAP_MAX);
    end

    // Previous lrclk sample and gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lrclk_q <= 1'b0;
            gap_q   <= {GAP_W{1'b0}};
        end else begin
            lrclk_q <= lrclk;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: rtl/startup_seq.sv
// Audio power-up sequencer: power settle, codec config with retries,
// LRCLK lock, DSP release, amplifier enable, and relock on LRCLK loss.
module startup_seq
    import eq_pkg::*;
#(
    parameter int PWR_DLY    = DEF_PWR_DLY,
    parameter int CFG_TMO    = DEF_CFG_TMO,
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int LOCK_EDGES = DEF_LOCK_EDGES,
    parameter int MAX_GAP    = DEF_MAX_GAP,
    parameter int AMP_DLY    = DEF_AMP_DLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lrclk,
    input  logic       cfg_ack,
    input  logic       cfg_err,
    output logic       cfg_req,
    output logic       dsp_rst,
    output logic       amp_en,
    output logic       seq_ready,
    output logic       fault,
    output logic [2:0] state_o
);

    // One timer serves PWR, CFG and RUN; it is cleared on every state change.
    localparam int               TMR_W    = cnt_w(max3(PWR_DLY, CFG_TMO, AMP_DLY));
    localparam int               RTY_W    = cnt_w(MAX_RETRY);
    localparam int               EDG_W    = cnt_w(LOCK_EDGES);
    localparam logic [TMR_W-1:0] PWR_LAST = TMR_W'(PWR_DLY - 32'sd1);
    localparam logic [TMR_W-1:0] CFG_LAST = TMR_W'(CFG_TMO - 32'sd1);
    localparam logic [TMR_W-1:0] AMP_LAST = TMR_W'(AMP_DLY - 32'sd1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 32'sd1);
    localparam logic [EDG_W-1:0] EDG_LAST = EDG_W'(LOCK_EDGES - 32'sd1);

    seq_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d, tmr_n;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic [EDG_W-1:0] edg_q, edg_d, edg_n;
    logic             amp_n, chg;
    logic             cfg_req_q, cfg_req_d;
    logic             dsp_rst_q, dsp_rst_d;
    logic             amp_en_q, amp_en_d;
    logic             seq_ready_q, seq_ready_d;
    logic             fault_q, fault_d;
    logic             lr_rise, gap_exceeded;

    lr_gap_mon #(
        .MAX_GAP (MAX_GAP)
    ) u_gap_mon (
        .clk          (clk),
        .rst          (rst),
        .lrclk        (lrclk),
        .lr_rise      (lr_rise),
        .gap_exceeded (gap_exceeded)
    );

    // Next state, counters and registered-output values.
    always_comb begin
        state_d = state_q;
        tmr_n   = tmr_q;
        rty_d   = rty_q;
        edg_n   = edg_q;
        amp_n   = amp_en_q;
        case (state_q)
            ST_PWR: begin
                if (tmr_q == PWR_LAST) begin
                    state_d = ST_CFG;
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end
            ST_CFG: begin
                // Ack has priority over a simultaneous err or the timeout.
                if (cfg_ack) begin
                    state_d = ST_LOCK;
                    rty_d   = {RTY_W{1'b0}};
                end else if (cfg_err || (tmr_q == CFG_LAST)) begin
                    if (rty_q == RTY_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_CFGW;
                        rty_d   = rty_q + RTY_W'(1);
                    end
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end
            ST_CFGW: begin
                state_d = ST_CFG;
            end
            ST_LOCK: begin
                if (lr_rise) begin
                    if (edg_q == EDG_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        edg_n = edg_q + EDG_W'(1);
                    end
                end else if (gap_exceeded) begin
                    edg_n = {EDG_W{1'b0}};
                end else begin
                    edg_n = edg_q;
                end
            end
            ST_RUN: begin
                if (gap_exceeded) begin
                    state_d = ST_LOCK;
                end else if (amp_en_q) begin
                    tmr_n = tmr_q;
                end else if (tmr_q == AMP_LAST) begin
                    amp_n = 1'b1;
                end else begin
                    tmr_n = tmr_q + TMR_W'(1);
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_PWR;
            end
        endcase

        chg         = (state_d != state_q);
        tmr_d       = chg ? {TMR_W{1'b0}} : tmr_n;
        edg_d       = chg ? {EDG_W{1'b0}} : edg_n;
        amp_en_d    = chg ? 1'b0 : amp_n;
        seq_ready_d = amp_en_d;
        cfg_req_d   = (state_d == ST_CFG);
        dsp_rst_d   = (state_d != ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWR;
            tmr_q       <= {TMR_W{1'b0}};
            rty_q       <= {RTY_W{1'b0}};
            edg_q       <= {EDG_W{1'b0}};
            cfg_req_q   <= 1'b0;
            dsp_rst_q   <= 1'b1;
            amp_en_q    <= 1'b0;
            seq_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            rty_q       <= rty_d;
            edg_q       <= edg_d;
            cfg_req_q   <= cfg_req_d;
            dsp_rst_q   <= dsp_rst_d;
            amp_en_q    <= amp_en_d;
            seq_ready_q <= seq_ready_d;
            fault_q     <= fault_d;
        end
    end

    assign cfg_req   = cfg_req_q;
    assign dsp_rst   = dsp_rst_q;
    assign amp_en    = amp_en_q;
    assign seq_ready = seq_ready_q;
    assign fault     = fault_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_startup_seq.sv
// Scoreboard bench for startup_seq: stimulus queues the expected output
// vector and the cycle it must appear; a monitor checks every output change.
module tb_startup_seq;

    // {state_o, cfg_req, dsp_rst, amp_en, seq_ready, fault}
    localparam logic [7:0] V_PWR   = {3'd0, 5'b01000};
    localparam logic [7:0] V_CFG   = {3'd1, 5'b11000};
    localparam logic [7:0] V_CFGW  = {3'd2, 5'b01000};
    localparam logic [7:0] V_LOCK  = {3'd3, 5'b01000};
    localparam logic [7:0] V_RUN0  = {3'd4, 5'b00000};
    localparam logic [7:0] V_RUN1  = {3'd4, 5'b00110};
    localparam logic [7:0] V_FAULT = {3'd5, 5'b01001};

    logic       clk, rst, lrclk, cfg_ack, cfg_err;
    logic       cfg_req, dsp_rst, amp_en, seq_ready, fault;
    logic [2:0] state_o;
    logic [7:0] obs;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_rise = 0;
    int cfg_start = 0;

    int         exp_cyc_q[$];
    logic [7:0] exp_val_q[$];
    string      exp_name_q[$];

    startup_seq #(
        .PWR_DLY    (10),
        .CFG_TMO    (20),
        .MAX_RETRY  (3),
        .LOCK_EDGES (8),
        .MAX_GAP    (40),
        .AMP_DLY    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lrclk     (lrclk),
        .cfg_ack   (cfg_ack),
        .cfg_err   (cfg_err),
        .cfg_req   (cfg_req),
        .dsp_rst   (dsp_rst),
        .amp_en    (amp_en),
        .seq_ready (seq_ready),
        .fault     (fault),
        .state_o   (state_o)
    );

    assign obs = {state_o, cfg_req, dsp_rst, amp_en, seq_ready, fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after the n-th rising edge cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of the output vector is matched against the queue.
    initial begin : monitor
        logic [7:0] prev;
        int         ec;
        logic [7:0] ev;
        string      en;
        prev = 8'bx;
        forever begin
            @(negedge clk);
            if (obs !== prev) begin
                total++;
                if (exp_val_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cyc=%0d got=%h, no change expected", cyc, obs);
                end else begin
                    ec = exp_cyc_q.pop_front();
                    ev = exp_val_q.pop_front();
                    en = exp_name_q.pop_front();
                    if ((ec != cyc) || (ev !== obs)) begin
                        bad++;
                        $display("FAIL %s: got cyc=%0d val=%h, expected cyc=%0d val=%h",
                                 en, cyc, obs, ec, ev);
                    end
                end
            end
            prev = obs;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        tick(c - cyc);
    endtask

    task automatic expect_at(input int c, input logic [7:0] v, input string nm);
        exp_cyc_q.push_back(c);
        exp_val_q.push_back(v);
        exp_name_q.push_back(nm);
    endtask

    task automatic pulse(input logic a, input logic e);
        cfg_ack = a;
        cfg_err = e;
        tick(1);
        cfg_ack = 1'b0;
        cfg_err = 1'b0;
    endtask

    // Reset for n edges; cfg_req must rise exactly 10 edges after release.
    task automatic do_reset(input int n);
        expect_at(cyc + 1, V_PWR, "reset_state");
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        cfg_start = cyc + 10;
        expect_at(cfg_start, V_CFG, "cfg_req_rise");
    endtask

    task automatic lr_periods(input int n);
        for (int i = 0; i < n; i++) begin
            lrclk = 1'b1;
            last_rise = cyc + 1;
            tick(16);
            lrclk = 1'b0;
            tick(16);
        end
    endtask

    task automatic relock(input string tag);
        expect_at(cyc + 1 + 7 * 32, V_RUN0, {tag, "_dsp_release"});
        expect_at(cyc + 5 + 7 * 32, V_RUN1, {tag, "_amp_en"});
    endtask

    initial begin : stimulus
        rst     = 1'b1;
        lrclk   = 1'b0;
        cfg_ack = 1'b0;
        cfg_err = 1'b0;

        // Nominal power-up, lock, then lock loss and relock without new config.
        do_reset(3);
        wait_until(cfg_start);
        tick(4);
        expect_at(cyc + 1, V_LOCK, "lock_on_ack");
        pulse(1'b1, 1'b0);
        relock("nominal");
        lr_periods(10);
        expect_at(last_rise + 40, V_LOCK, "lock_loss");
        wait_until(last_rise + 45);
        relock("relock");
        lr_periods(8);

        // Timeout on the first request, ack on the second.
        do_reset(2);
        wait_until(cfg_start);
        expect_at(cfg_start + 20, V_CFGW, "timeout");
        expect_at(cfg_start + 21, V_CFG, "retry_after_timeout");
        wait_until(cfg_start + 21);
        tick(5);
        expect_at(cyc + 1, V_LOCK, "lock_after_retry");
        pulse(1'b1, 1'b0);
        tick(10);

        // Reset while cfg_req is high, then err followed by simultaneous ack+err.
        do_reset(1);
        wait_until(cfg_start);
        tick(3);
        do_reset(1);
        wait_until(cfg_start);
        tick(2);
        expect_at(cyc + 1, V_CFGW, "err_gap");
        expect_at(cyc + 2, V_CFG, "req_after_err");
        pulse(1'b0, 1'b1);
        tick(2);
        expect_at(cyc + 1, V_LOCK, "ack_beats_err");
        pulse(1'b1, 1'b1);
        tick(10);

        // Every attempt answered with err: three requests, then terminal fault.
        do_reset(1);
        wait_until(cfg_start);
        for (int k = 0; k < 3; k++) begin
            tick(2);
            if (k < 2) begin
                expect_at(cyc + 1, V_CFGW, "err_gap");
                expect_at(cyc + 2, V_CFG, "req_after_err");
            end else begin
                expect_at(cyc + 1, V_FAULT, "fault_entry");
            end
            pulse(1'b0, 1'b1);
        end
        lr_periods(31);
        tick(8);
        total++;
        if (obs !== V_FAULT) begin
            bad++;
            $display("FAIL fault_hold: got %h, expected %h", obs, V_FAULT);
        end

        do_reset(2);
        tick(15);

        total++;
        if (exp_val_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: %0d left, expected 0 (next %s at cyc %0d)",
                     exp_val_q.size(), exp_name_q[0], exp_cyc_q[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
